invader_board: RTL and testbench

Single-clock game-board engine for the Space Invaders datapath. It is the parametrised successor to the flat board-state matrix and owns every piece of board state:
- alien formation bitmap with edge-bounce march and step-down;
- player column;
- one player laser with alien collision;
- win/lose detection.

It publishes a 2-bit-per-cell flattened board to the renderer. Movement rates come from single-cycle tick enables generated upstream, not from separate clocks.

---
 rtl/invader_board.sv | 221 ++++++++++++++++++++++
 tb/tb_invader_board.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/invader_board.sv
// Purpose : Space Invaders board engine: alien formation, player, single laser, win/lose flags.
// Latency : state updates on the clk edge that samples a tick/button edge; outputs decode state with 0 cycles of latency.
// Backpres: none; fire requests that arrive while a laser is in flight are dropped, not queued.
//
// Ports:
//   clk, rst          - single clock, synchronous active-high reset
//   block_tick        - one-cycle enable: formation marches one step
//   laser_tick        - one-cycle enable: laser climbs one row
//   player_move_tick  - one-cycle enable: player may move (btn_adj / btn_left_right)
//   btn_shoot         - level; the rising edge fires when no laser is active
//   state_matrix_out  - 2 bits per cell, cell i = r*x_size+c (00 empty, 01 alien, 10 player, 11 laser)
//   alien_count       - live aliens
//   game_over/game_won - sticky end-of-game flags; either one freezes the board until rst
module invader_board #(
    parameter int x_size       = 8,
    parameter int y_size       = 10,
    parameter int x_num_blocks = 4,
    parameter int y_num_blocks = 3
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          block_tick,
    input  logic                                          laser_tick,
    input  logic                                          player_move_tick,
    input  logic                                          btn_adj,
    input  logic                                          btn_left_right,
    input  logic                                          btn_shoot,
    output logic [2*x_size*y_size-1:0]                    state_matrix_out,
    output logic [$clog2(x_num_blocks*y_num_blocks+1)-1:0] alien_count,
    output logic                                          game_over,
    output logic                                          game_won
);

    localparam int col_w     = $clog2(x_size);
    localparam int row_w     = $clog2(y_size);
    localparam int cnt_w     = $clog2(x_num_blocks*y_num_blocks+1);
    localparam int num_alien = x_num_blocks * y_num_blocks;

    localparam logic [col_w-1:0] col_max    = col_w'(x_size - 1);
    localparam logic [col_w-1:0] col_start  = col_w'(x_size / 2);
    localparam logic [row_w-1:0] row_spawn  = row_w'(y_size - 2);
    localparam logic [cnt_w-1:0] cnt_start  = cnt_w'(num_alien);

    // Row-major alien bitmap: alien_map[row][col], row 0 at the top.
    typedef logic [y_size-1:0][x_size-1:0] map_t;

    typedef struct packed {
        logic             active;
        logic [row_w-1:0] row;
        logic [col_w-1:0] col;
    } laser_t;

    function automatic map_t init_map();
        map_t m;
        m = '0;
        for (int r = 0; r < y_num_blocks; r++) begin
            for (int c = 0; c < x_num_blocks; c++) begin
                m[r][c] = 1'b1;
            end
        end
        return m;
    endfunction

    localparam map_t map_init = init_map();

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    map_t             alien_map;
    logic             dir;          // 1 = marching right
    logic [col_w-1:0] player_col;
    laser_t           laser;
    logic             shoot_prev;
    logic [cnt_w-1:0] alien_cnt;
    logic             over_q;
    logic             won_q;

    // Next-state
    map_t             map_n;
    logic             dir_n;
    logic [col_w-1:0] pcol_n;
    laser_t           laser_n;
    logic [cnt_w-1:0] cnt_n;
    logic             over_n;
    logic             won_n;

    logic             frozen;
    logic             fire;
    logic             edge_hit;
    logic             bottom_hit;

    assign frozen = over_q | won_q;

    // ------------------------------------------------------------------
    // Next-state logic. Order inside one cycle: formation and laser move
    // (or spawn) first, then a single collision check on the resulting
    // positions, then the loss/win evaluation on the post-collision map.
    // ------------------------------------------------------------------
    always_comb begin
        map_n      = alien_map;
        dir_n      = dir;
        pcol_n     = player_col;
        laser_n    = laser;
        cnt_n      = alien_cnt;
        over_n     = over_q;
        won_n      = won_q;
        fire       = 1'b0;
        edge_hit   = 1'b0;
        bottom_hit = 1'b0;

        if (!frozen) begin
            // Formation: march sideways, or step down and turn around when
            // the leading edge column is occupied.
            if (block_tick) begin
                for (int r = 0; r < y_size; r++) begin
                    edge_hit = edge_hit | (dir ? alien_map[r][x_size-1] : alien_map[r][0]);
                end
                if (edge_hit) begin
                    map_n[0] = '0;
                    for (int r = 1; r < y_size; r++) begin
                        map_n[r] = alien_map[r-1];
                    end
                    dir_n = ~dir;
                end else begin
                    for (int r = 0; r < y_size; r++) begin
                        map_n[r] = dir ? (alien_map[r] << 1) : (alien_map[r] >> 1);
                    end
                end
            end

            // Player: saturating move.
            if (player_move_tick && btn_adj) begin
                if (btn_left_right) begin
                    if (player_col != col_max) pcol_n = player_col + col_w'(1);
                end else begin
                    if (player_col != '0) pcol_n = player_col - col_w'(1);
                end
            end

            // Fire spawns from the pre-move column and suppresses the
            // laser_tick in the same cycle (a fresh laser never advances on
            // its spawn edge).
            fire = btn_shoot && !shoot_prev && !laser.active;
            if (fire) begin
                laser_n.active = 1'b1;
                laser_n.row    = row_spawn;
                laser_n.col    = player_col;
            end else if (laser_tick && laser.active) begin
                if (laser.row == '0) begin
                    laser_n.active = 1'b0;
                end else begin
                    laser_n.row = laser.row - row_w'(1);
                end
            end

            // Collision on post-move positions. A laser and an alien that
            // swap cells in the same edge are deliberately not detected.
            if (laser_n.active && map_n[laser_n.row][laser_n.col]) begin
                map_n[laser_n.row][laser_n.col] = 1'b0;
                laser_n.active                  = 1'b0;
                cnt_n                           = alien_cnt - cnt_w'(1);
            end

            // Loss is checked after the kill, so a shot that clears the
            // last bottom-row alien saves the game. With no aliens left
            // the bottom row is empty, so loss and win are exclusive.
            bottom_hit = |map_n[y_size-1];
            if (bottom_hit) over_n = 1'b1;
            if (cnt_n == '0) won_n = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            alien_map  <= map_init;
            dir        <= 1'b1;
            player_col <= col_start;
            laser      <= '0;
            shoot_prev <= 1'b1;     // a button held through reset must not fire
            alien_cnt  <= cnt_start;
            over_q     <= 1'b0;
            won_q      <= 1'b0;
        end else begin
            alien_map  <= map_n;
            dir        <= dir_n;
            player_col <= pcol_n;
            laser      <= laser_n;
            shoot_prev <= btn_shoot; // keeps tracking even while frozen
            alien_cnt  <= cnt_n;
            over_q     <= over_n;
            won_q      <= won_n;
        end
    end

    // ------------------------------------------------------------------
    // Board decode, priority laser > player > alien > empty.
    // ------------------------------------------------------------------
    logic [1:0] cell_code;

    always_comb begin
        state_matrix_out = '0;
        cell_code        = 2'b00;
        for (int r = 0; r < y_size; r++) begin
            for (int c = 0; c < x_size; c++) begin
                cell_code = 2'b00;
                if (alien_map[r][c]) cell_code = 2'b01;
                if ((r == y_size - 1) && (c == int'(player_col))) cell_code = 2'b10;
                if (laser.active && (r == int'(laser.row)) && (c == int'(laser.col))) cell_code = 2'b11;
                state_matrix_out[2*(r*x_size+c) +: 2] = cell_code;
            end
        end
    end

    assign alien_count = alien_cnt;
    assign game_over   = over_q;
    assign game_won    = won_q;

endmodule

// File: tb/tb_invader_board.sv
// Purpose : directed scoreboard bench for invader_board (8x10 board, 4x3 aliens).
// Latency : expectations are queued one edge after stimulus and checked on the following negedge.
// Backpres: none; the monitor drains every queued expectation each negedge.
module tb_invader_board;

    logic         clk;
    logic         rst;
    logic         block_tick;
    logic         laser_tick;
    logic         player_move_tick;
    logic         btn_adj;
    logic         btn_left_right;
    logic         btn_shoot;
    logic [159:0] state_matrix_out;
    logic [3:0]   alien_count;
    logic         game_over;
    logic         game_won;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string        name;
        logic [159:0] board;
        logic [3:0]   cnt;
        logic         over;
        logic         won;
    } exp_t;

    exp_t sb_q[$];

    invader_board #(
        .x_size(8), .y_size(10), .x_num_blocks(4), .y_num_blocks(3)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .block_tick       (block_tick),
        .laser_tick       (laser_tick),
        .player_move_tick (player_move_tick),
        .btn_adj          (btn_adj),
        .btn_left_right   (btn_left_right),
        .btn_shoot        (btn_shoot),
        .state_matrix_out (state_matrix_out),
        .alien_count      (alien_count),
        .game_over        (game_over),
        .game_won         (game_won)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected board: alien rectangle rows r0..r1 / cols c0..c1, one optional
    // cleared cell (hole), player on row 9, optional laser (lrow < 0 = none).
    function automatic logic [159:0] mk_board(input int r0, input int r1, input int c0, input int c1,
                                              input int hole, input int pcol, input int lrow, input int lcol);
        logic [159:0] b;
        b = '0;
        for (int r = r0; r <= r1; r++) begin
            for (int c = c0; c <= c1; c++) begin
                b[2*(r*8+c) +: 2] = 2'b01;
            end
        end
        if (hole >= 0) b[2*hole +: 2] = 2'b00;
        b[2*(72+pcol) +: 2] = 2'b10;
        if (lrow >= 0) b[2*(lrow*8+lcol) +: 2] = 2'b11;
        return b;
    endfunction

    task automatic expect_st(input string n, input logic [159:0] b, input int cnt,
                             input logic ov, input logic wn);
        exp_t e;
        e.name  = n;
        e.board = b;
        e.cnt   = 4'(cnt);
        e.over  = ov;
        e.won   = wn;
        sb_q.push_back(e);
    endtask

    task automatic cyc(input logic bt, input logic lt, input logic pt);
        block_tick       = bt;
        laser_tick       = lt;
        player_move_tick = pt;
        @(posedge clk);
        #1;
        block_tick       = 1'b0;
        laser_tick       = 1'b0;
        player_move_tick = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    // Monitor: compare every queued expectation at the negedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if (state_matrix_out !== e.board) begin
                    errors++;
                    $display("FAIL %s board got %h want %h", e.name, state_matrix_out, e.board);
                end
                checks++;
                if (alien_count !== e.cnt) begin
                    errors++;
                    $display("FAIL %s alien_count got %0d want %0d", e.name, alien_count, e.cnt);
                end
                checks++;
                if (game_over !== e.over || game_won !== e.won) begin
                    errors++;
                    $display("FAIL %s flags got over=%b won=%b want over=%b won=%b",
                             e.name, game_over, game_won, e.over, e.won);
                end
            end
        end
    end

    logic [159:0] reset_board;
    int           pexp[5] = '{5, 6, 7, 7, 7};

    initial begin
        rst = 1'b1; block_tick = 1'b0; laser_tick = 1'b0; player_move_tick = 1'b0;
        btn_adj = 1'b0; btn_left_right = 1'b0; btn_shoot = 1'b0;
        reset_board = mk_board(0, 2, 0, 3, -1, 4, -1, 0);
        repeat (2) @(posedge clk);
        #1;

        // Reset
        do_reset();
        expect_st("reset", reset_board, 12, 1'b0, 1'b0);

        // March right, step down at the edge, then march left
        cyc(1'b1, 1'b0, 1'b0);
        expect_st("march1", mk_board(0, 2, 1, 4, -1, 4, -1, 0), 12, 1'b0, 1'b0);
        repeat (3) cyc(1'b1, 1'b0, 1'b0);
        expect_st("march4", mk_board(0, 2, 4, 7, -1, 4, -1, 0), 12, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        expect_st("march5_down", mk_board(1, 3, 4, 7, -1, 4, -1, 0), 12, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        expect_st("march6_left", mk_board(1, 3, 3, 6, -1, 4, -1, 0), 12, 1'b0, 1'b0);

        // Player moves right and saturates at col 7
        do_reset();
        btn_adj = 1'b1; btn_left_right = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 1'b0, 1'b1);
            expect_st($sformatf("player_r%0d", k+1), mk_board(0, 2, 0, 3, -1, pexp[k], -1, 0), 12, 1'b0, 1'b0);
        end
        btn_adj = 1'b0;
        cyc(1'b0, 1'b0, 1'b1);
        expect_st("player_noadj", mk_board(0, 2, 0, 3, -1, 7, -1, 0), 12, 1'b0, 1'b0);
        btn_adj = 1'b1; btn_left_right = 1'b0;
        repeat (8) cyc(1'b0, 1'b0, 1'b1);
        expect_st("player_left_sat", mk_board(0, 2, 0, 3, -1, 0, -1, 0), 12, 1'b0, 1'b0);
        btn_adj = 1'b0;

        // Hit: aliens at cols 1-4, shoot from col 4
        do_reset();
        cyc(1'b1, 1'b0, 1'b0);
        btn_shoot = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        expect_st("hit_spawn", mk_board(0, 2, 1, 4, -1, 4, 8, 4), 12, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            cyc(1'b0, 1'b1, 1'b0);
            expect_st($sformatf("hit_climb%0d", k), mk_board(0, 2, 1, 4, -1, 4, 8-k, 4), 12, 1'b0, 1'b0);
        end
        cyc(1'b0, 1'b1, 1'b0);
        expect_st("hit_kill", mk_board(0, 2, 1, 4, 20, 4, -1, 0), 11, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, 1'b0);
        expect_st("hit_held_nofire", mk_board(0, 2, 1, 4, 20, 4, -1, 0), 11, 1'b0, 1'b0);
        btn_shoot = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        btn_shoot = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        expect_st("hit_refire", mk_board(0, 2, 1, 4, 20, 4, 8, 4), 11, 1'b0, 1'b0);
        btn_shoot = 1'b0;

        // Miss: laser at col 4 climbs out of row 0
        do_reset();
        cyc(1'b0, 1'b0, 1'b0);
        btn_shoot = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        repeat (8) cyc(1'b0, 1'b1, 1'b0);
        expect_st("miss_row0", mk_board(0, 2, 0, 3, -1, 4, 0, 4), 12, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        expect_st("miss_gone", reset_board, 12, 1'b0, 1'b0);
        btn_shoot = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);

        // Fire + laser_tick + move right in one edge: spawn only, pre-move column
        btn_shoot = 1'b1; btn_adj = 1'b1; btn_left_right = 1'b1;
        cyc(1'b0, 1'b1, 1'b1);
        expect_st("fire_move_tick", mk_board(0, 2, 0, 3, -1, 5, 8, 4), 12, 1'b0, 1'b0);

        // Reset mid-flight with every tick asserted, button held through it
        rst = 1'b1;
        cyc(1'b1, 1'b1, 1'b1);
        rst = 1'b0;
        expect_st("rst_midflight", reset_board, 12, 1'b0, 1'b0);
        btn_adj = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        expect_st("held_thru_reset", reset_board, 12, 1'b0, 1'b0);
        btn_shoot = 1'b0;

        // Lose: bottom alien row reaches row 9 on the 35th step
        do_reset();
        repeat (34) cyc(1'b1, 1'b0, 1'b0);
        expect_st("lose_tick34", mk_board(6, 8, 4, 7, -1, 4, -1, 0), 12, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        expect_st("lose_tick35", mk_board(7, 9, 4, 7, -1, 4, -1, 0), 12, 1'b1, 1'b0);
        btn_adj = 1'b1; btn_left_right = 1'b0; btn_shoot = 1'b1;
        repeat (3) cyc(1'b1, 1'b1, 1'b1);
        expect_st("lose_frozen", mk_board(7, 9, 4, 7, -1, 4, -1, 0), 12, 1'b1, 1'b0);
        btn_adj = 1'b0; btn_shoot = 1'b0;
        do_reset();
        expect_st("lose_reset", reset_board, 12, 1'b0, 1'b0);

        // Drain the scoreboard with a bounded wait
        for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(negedge clk);
        @(posedge clk);
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d want 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
